right_shift_seq: RTL

//   Multi-cycle right shifter: shifts a WIDTH-bit operand right by 0..WIDTH-1 positions, one bit per clock.

---
 rtl/right_shift_seq_if.sv | 24 ++
 rtl/right_shift_seq.sv | 96 +++++++++
 2 files changed

// File: rtl/right_shift_seq_if.sv
// ============================================================================
// Module   : right_shift_seq_if
// Purpose  : Start/busy/done handshake and operand/result bus for right_shift_seq.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface right_shift_seq_if #(
    parameter int WIDTH    = 16,
    parameter int AMT_BITS = 4
);
    logic                start;
    logic [WIDTH-1:0]    in;
    logic [AMT_BITS-1:0] amt;
    logic                arith;
    logic                busy;
    logic                done;
    logic [WIDTH-1:0]    out;

    modport master (output start, in, amt, arith, input busy, done, out);
    modport slave  (input start, in, amt, arith, output busy, done, out);
endinterface

`default_nettype wire

// File: rtl/right_shift_seq.sv
// ============================================================================
// Module   : right_shift_seq
// Purpose  : Multi-cycle logical/arithmetic right shifter, one bit per clock.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module right_shift_seq #(
    parameter int WIDTH    = 16,
    parameter int AMT_BITS = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    right_shift_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_sreg;
    logic [WIDTH-1:0]    r_out;
    logic [AMT_BITS-1:0] r_cnt;
    logic                r_fill;

    logic                w_accept;
    logic                w_amt_zero;
    logic                w_last;
    logic [WIDTH-1:0]    w_shifted;

    // Start is only honoured when no operation is in flight.
    assign w_accept   = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_amt_zero = (bus.amt == '0);
    assign w_last     = (r_cnt == AMT_BITS'(1));
    assign w_shifted  = {r_fill, r_sreg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_nxt = S_IDLE;
                if (w_accept) begin
                    w_state_nxt = w_amt_zero ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sreg <= '0;
            r_cnt  <= '0;
            r_fill <= 1'b0;
            r_out  <= '0;
        end else if (w_accept) begin
            r_sreg <= bus.in;
            r_cnt  <= bus.amt;
            r_fill <= bus.arith & bus.in[WIDTH-1];
            if (w_amt_zero) begin
                r_out <= bus.in;
            end
        end else if (r_state == S_SHIFT) begin
            r_sreg <= w_shifted;
            r_cnt  <= r_cnt - AMT_BITS'(1);
            // Result register only sees the final value, never intermediate shifts.
            if (w_last) begin
                r_out <= w_shifted;
            end
        end
    end

    assign bus.busy = (r_state == S_SHIFT);
    assign bus.done = (r_state == S_DONE);
    assign bus.out  = r_out;

endmodule

`default_nettype wire
